// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and types for the 512x32 synchronous FIFO controller.
package fifo_ctrl_pkg;

   localparam int unsigned FIFO_ADDR_W    = 9;
   localparam int unsigned FIFO_DATA_W    = 32;
   localparam int unsigned FIFO_DEPTH     = 2 ** FIFO_ADDR_W;
   localparam int unsigned FIFO_AFULL_TH  = 480;
   localparam int unsigned FIFO_AEMPTY_TH = 16;

   typedef logic [FIFO_ADDR_W:0] fifo_ptr_t;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// FIFO pointer register: ADDR_W address bits plus a wrap bit, advanced by one per accept.
module fifo_ptr_cnt
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   output logic [ADDR_W:0]   ptr
);

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + (ADDR_W + 1)'(1);
      end
   end

endmodule

// File: rtl/fifo_sync_ctrl_512x32.sv
// Single-clock FIFO controller for the 512x32 two-port LSRAM: pointers, count, flags, DVLD.
// Optional sticky OVERFLOW/UNDERFLOW flags are built only with FIFO_CTRL_ERR_FLAGS_EN defined.
module fifo_sync_ctrl_512x32
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W    = FIFO_ADDR_W,
   parameter int unsigned DATA_W    = FIFO_DATA_W,
   parameter int unsigned AFULL_TH  = FIFO_AFULL_TH,
   parameter int unsigned AEMPTY_TH = FIFO_AEMPTY_TH
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                WE,
   input  logic [DATA_W-1:0]   DATA,
   input  logic                RE,
   output logic [DATA_W-1:0]   Q,
   output logic                DVLD,
   output logic                FULL,
   output logic                EMPTY,
   output logic                AFULL,
   output logic                AEMPTY,
   output logic [ADDR_W:0]     COUNT,
   output logic                OVERFLOW,
   output logic                UNDERFLOW,
   output logic [DATA_W-1:0]   RAM_W_DATA,
   output logic [ADDR_W-1:0]   RAM_W_ADDR,
   output logic [ADDR_W-1:0]   RAM_R_ADDR,
   output logic                RAM_W_EN,
   output logic                RAM_R_EN,
   input  logic [DATA_W-1:0]   RAM_R_DATA
);

   localparam logic [ADDR_W:0] DEPTH_C    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] AFULL_C    = (ADDR_W + 1)'(AFULL_TH);
   localparam logic [ADDR_W:0] AEMPTY_C   = (ADDR_W + 1)'(AEMPTY_TH);

   logic              wr_ok;
   logic              rd_ok;
   logic [ADDR_W:0]   wptr;
   logic [ADDR_W:0]   rptr;
   logic [ADDR_W:0]   count_nxt;

   // RESET gates both enables so no RAM access or pointer step happens in the reset cycle.
   assign wr_ok = WE & ~FULL  & ~RESET;
   assign rd_ok = RE & ~EMPTY & ~RESET;

   assign RAM_W_EN   = wr_ok;
   assign RAM_R_EN   = rd_ok;
   assign RAM_W_DATA = DATA;
   assign RAM_W_ADDR = wptr[ADDR_W-1:0];
   assign RAM_R_ADDR = rptr[ADDR_W-1:0];
   assign Q          = RAM_R_DATA;

   fifo_ptr_cnt #(.ADDR_W(ADDR_W)) u_wptr (
      .clk   (CLK),
      .reset (RESET),
      .inc   (wr_ok),
      .ptr   (wptr)
   );

   fifo_ptr_cnt #(.ADDR_W(ADDR_W)) u_rptr (
      .clk   (CLK),
      .reset (RESET),
      .inc   (rd_ok),
      .ptr   (rptr)
   );

   assign count_nxt = COUNT + {{ADDR_W{1'b0}}, wr_ok} - {{ADDR_W{1'b0}}, rd_ok};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         COUNT  <= '0;
         FULL   <= 1'b0;
         EMPTY  <= 1'b1;
         AFULL  <= 1'b0;
         AEMPTY <= 1'b1;
         DVLD   <= 1'b0;
      end else begin
         COUNT  <= count_nxt;
         FULL   <= (count_nxt == DEPTH_C);
         EMPTY  <= (count_nxt == '0);
         AFULL  <= (count_nxt >= AFULL_C);
         AEMPTY <= (count_nxt <= AEMPTY_C);
         DVLD   <= rd_ok;
      end
   end

   // Occupancy must always equal the wrap-aware pointer distance.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         assert (COUNT == (wptr - rptr));
      end
   end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         OVERFLOW  <= 1'b0;
         UNDERFLOW <= 1'b0;
      end else begin
         if (WE & FULL) begin
            OVERFLOW <= 1'b1;
         end
         if (RE & EMPTY) begin
            UNDERFLOW <= 1'b1;
         end
      end
   end
`else
   assign OVERFLOW  = 1'b0;
   assign UNDERFLOW = 1'b0;
`endif

endmodule
